// File: rtl/rx_frame_fifo_if.sv
// AXI-Stream bundle shared by the Rx frame buffer input and output.
// Ports: tdata/tkeep/tvalid/tlast/tuser (master->slave), tready (slave->master).
interface rx_frame_fifo_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tuser;
  logic        tready;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/rx_frame_fifo.sv
// Store-and-forward Rx frame buffer: commits CRC-good frames, rewinds others.
// Ports: i_clk, i_reset (sync, high); s_axis (slave, no back-pressure);
//   m_axis (master); o_frames_ok/bad/ovf counters; o_fill (incl. partial).
module rx_frame_fifo #(
  parameter  int DEPTH  = 512,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  rx_frame_fifo_if.slave  s_axis,
  rx_frame_fifo_if.master m_axis,
  output logic [15:0]     o_frames_ok,
  output logic [15:0]     o_frames_bad,
  output logic [15:0]     o_frames_ovf,
  output logic [ADDR_W:0] o_fill
);

  typedef enum logic {ACCEPT, DISCARD} wr_st_e;
  typedef logic [ADDR_W:0] ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  logic [36:0] mem [DEPTH];

  ptr_t   wr_ptr, cm_ptr, rd_ptr;
  ptr_t   wr_nx, cm_nx;
  wr_st_e st, st_nx;
  logic   we, full;
  logic   inc_ok, inc_bad, inc_ovf;

  assign s_axis.tready = 1'b1;
  assign full   = (wr_ptr - rd_ptr) == DEPTH_P;
  assign o_fill = wr_ptr - rd_ptr;

  // Write decision first; the end event then overrides the pointers.
  always_comb begin
    st_nx   = st;
    wr_nx   = wr_ptr;
    cm_nx   = cm_ptr;
    we      = 1'b0;
    inc_ok  = 1'b0;
    inc_bad = 1'b0;
    inc_ovf = 1'b0;
    unique case (st)
      ACCEPT: begin
        if (s_axis.tvalid && !full) begin
          we    = 1'b1;
          wr_nx = wr_ptr + 1'b1;
        end
        if (s_axis.tlast) begin
          if (s_axis.tvalid && s_axis.tuser && !full) begin
            cm_nx  = wr_ptr + 1'b1;
            inc_ok = 1'b1;
          end else if (s_axis.tvalid && full) begin
            wr_nx   = cm_ptr;
            inc_ovf = 1'b1;
          end else begin
            wr_nx   = cm_ptr;
            inc_bad = 1'b1;
          end
        end else if (s_axis.tvalid && full) begin
          st_nx = DISCARD;
        end
      end
      DISCARD: begin
        if (s_axis.tlast) begin
          wr_nx   = cm_ptr;
          inc_ovf = 1'b1;
          st_nx   = ACCEPT;
        end
      end
      default: st_nx = ACCEPT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      st           <= ACCEPT;
      wr_ptr       <= '0;
      cm_ptr       <= '0;
      o_frames_ok  <= '0;
      o_frames_bad <= '0;
      o_frames_ovf <= '0;
    end else begin
      st     <= st_nx;
      wr_ptr <= wr_nx;
      cm_ptr <= cm_nx;
      if (inc_ok)  o_frames_ok  <= o_frames_ok + 1'b1;
      if (inc_bad) o_frames_bad <= o_frames_bad + 1'b1;
      if (inc_ovf) o_frames_ovf <= o_frames_ovf + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (we)
      mem[wr_ptr[ADDR_W-1:0]] <=
        {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
  end

  // Read side: RAM output register feeds a 2-entry skid. When the
  // skid is empty the RAM register drives the output directly.
  logic        s1_v;
  logic [36:0] ram_q;
  logic [36:0] sk [2];
  logic        hd;
  logic [1:0]  cnt;
  logic [1:0]  occ;
  logic [36:0] out_w;
  logic        pop, pop_sk, push, issue, rd_empty;

  assign rd_empty = rd_ptr == cm_ptr;
  assign out_w    = (cnt != 2'd0) ? sk[hd] : ram_q;

  assign m_axis.tvalid = (cnt != 2'd0) | s1_v;
  assign m_axis.tuser  = 1'b0;
  assign {m_axis.tlast, m_axis.tkeep, m_axis.tdata} = out_w;

  assign pop    = m_axis.tvalid & m_axis.tready;
  assign pop_sk = pop & (cnt != 2'd0);
  assign push   = s1_v & ~(pop & (cnt == 2'd0));
  // Beats held after this cycle; a new read needs a free slot.
  assign occ    = cnt + {1'b0, s1_v} - {1'b0, pop};
  assign issue  = ~rd_empty & (occ < 2'd2);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_ptr <= '0;
      s1_v   <= 1'b0;
      cnt    <= '0;
      hd     <= 1'b0;
      sk[0]  <= '0;
      sk[1]  <= '0;
    end else begin
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      s1_v <= issue;
      cnt  <= occ;
      if (push) sk[hd ^ cnt[0]] <= ram_q;
      if (pop_sk) hd <= ~hd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      ram_q <= '0;
    else if (issue)
      ram_q <= mem[rd_ptr[ADDR_W-1:0]];
  end

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Directed bench for rx_frame_fifo (DEPTH=16).
// Ports: drives s_if/m_if.tready, watches m_if, counters and fill.
module tb_rx_frame_fifo;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_frame_fifo_if s_if ();
  rx_frame_fifo_if m_if ();

  logic [15:0] ok_c, bad_c, ovf_c;
  logic [4:0]  fill;

  rx_frame_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .s_axis       (s_if.slave),
    .m_axis       (m_if.master),
    .o_frames_ok  (ok_c),
    .o_frames_bad (bad_c),
    .o_frames_ovf (ovf_c),
    .o_fill       (fill)
  );

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int stall_err = 0;
  int stall_chk = 0;
  bit rand_rdy = 1'b0;
  logic        held_v = 1'b0;
  logic [36:0] held;
  logic [36:0] q [$];

  always @(negedge clk) begin
    if (held_v) begin
      stall_chk++;
      if (!(m_if.tvalid === 1'b1 &&
            {m_if.tlast, m_if.tkeep, m_if.tdata} === held))
        stall_err++;
    end
    held_v = m_if.tvalid && !m_if.tready && !rst;
    held   = {m_if.tlast, m_if.tkeep, m_if.tdata};
    if (m_if.tvalid && m_if.tready && !rst)
      q.push_back({m_if.tlast, m_if.tkeep, m_if.tdata});
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) m_if.tready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tkeep  = 4'h0;
    s_if.tdata  = 32'h0;
  endtask

  task automatic beat(logic [31:0] d, logic lst);
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tkeep  = 4'hF;
    s_if.tlast  = lst;
    s_if.tuser  = 1'b0;
  endtask

  task automatic send_frame(int n, logic [31:0] base,
                            logic [3:0] lk, logic user);
    for (int i = 0; i < n; i++) begin
      beat(base + 32'(i), i == n - 1);
      if (i == n - 1) begin
        s_if.tkeep = lk;
        s_if.tuser = user;
      end
      tick();
    end
    idle();
  endtask

  task automatic wait_beats(string tag, int n, int budget);
    int c = 0;
    while (q.size() < n && c < budget) begin
      tick();
      c++;
    end
    repeat (3) tick();
    chk(tag, q.size(), n);
  endtask

  task automatic chk_frame(string tag, int off, int n,
                           logic [31:0] base, logic [3:0] lk);
    logic [36:0] exp, obs;
    for (int i = 0; i < n; i++) begin
      exp = {i == n - 1, (i == n - 1) ? lk : 4'hF, base + 32'(i)};
      obs = (off + i < q.size()) ? q[off + i] : '1;
      chk($sformatf("%s beat %0d", tag, i), obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    q.delete();
  endtask

  initial begin
    idle();
    m_if.tready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst tvalid", m_if.tvalid, 0);
    chk("rst tdata", m_if.tdata, 0);
    chk("rst tkeep", m_if.tkeep, 0);
    chk("rst tlast", m_if.tlast, 0);
    chk("rst ok", ok_c, 0);
    chk("rst bad", bad_c, 0);
    chk("rst ovf", ovf_c, 0);
    chk("rst fill", fill, 0);

    // 16-beat good frame, latency and content
    m_if.tready = 1'b1;
    q.delete();
    send_frame(16, 32'h0, 4'b0011, 1'b1);
    chk("t1 tvalid N+1", m_if.tvalid, 0);
    tick();
    chk("t1 tvalid N+2", m_if.tvalid, 1);
    chk("t1 data N+2", m_if.tdata, 0);
    wait_beats("t1 count", 16, 60);
    chk_frame("t1", 0, 16, 32'h0, 4'b0011);
    chk("t1 ok", ok_c, 1);
    chk("t1 fill", fill, 0);

    // bad CRC frame then good frame
    do_reset();
    send_frame(8, 32'h100, 4'hF, 1'b0);
    send_frame(4, 32'h200, 4'hF, 1'b1);
    wait_beats("t2 count", 4, 40);
    chk_frame("t2", 0, 4, 32'h200, 4'hF);
    chk("t2 bad", bad_c, 1);
    chk("t2 ok", ok_c, 1);
    chk("t2 fill", fill, 0);

    // abort via end event without a beat
    do_reset();
    for (int i = 0; i < 5; i++) begin
      beat(32'h250 + 32'(i), 1'b0);
      tick();
    end
    chk("t3 fill partial", fill, 5);
    idle();
    s_if.tlast = 1'b1;
    tick();
    idle();
    chk("t3 fill rewound", fill, 0);
    repeat (4) tick();
    chk("t3 none out", q.size(), 0);
    chk("t3 bad", bad_c, 1);
    send_frame(3, 32'h300, 4'hF, 1'b1);
    wait_beats("t3 count", 3, 30);
    chk_frame("t3", 0, 3, 32'h300, 4'hF);
    chk("t3 ok", ok_c, 1);

    // overflow with the reader stalled
    do_reset();
    m_if.tready = 1'b0;
    send_frame(10, 32'h400, 4'hF, 1'b1);
    send_frame(10, 32'h410, 4'hF, 1'b1);
    repeat (5) tick();
    chk("t4 ovf", ovf_c, 1);
    chk("t4 ok", ok_c, 1);
    chk("t4 bad", bad_c, 0);
    chk("t4 none out", q.size(), 0);
    m_if.tready = 1'b1;
    wait_beats("t4 count", 10, 40);
    chk_frame("t4a", 0, 10, 32'h400, 4'hF);
    q.delete();
    send_frame(6, 32'h480, 4'hF, 1'b1);
    chk("t4 fill peak", fill, 6);
    wait_beats("t4b count", 6, 30);
    chk_frame("t4b", 0, 6, 32'h480, 4'hF);
    chk("t4 ok2", ok_c, 2);

    // back-pressure, pointers continue across the wrap
    q.delete();
    rand_rdy = 1'b1;
    send_frame(7, 32'h500, 4'hF, 1'b1);
    send_frame(7, 32'h507, 4'hF, 1'b1);
    wait_beats("t5 count", 14, 400);
    rand_rdy = 1'b0;
    m_if.tready = 1'b1;
    chk_frame("t5a", 0, 7, 32'h500, 4'hF);
    chk_frame("t5b", 7, 7, 32'h507, 4'hF);
    chk("t5 ok", ok_c, 4);
    chk("t5 stall stable", stall_err, 0);
    chk("t5 stalls seen", stall_chk > 0, 1);
    chk("t5 fill", fill, 0);

    // reset during beat 3 of a frame
    do_reset();
    for (int i = 0; i < 2; i++) begin
      beat(32'h600 + 32'(i), 1'b0);
      tick();
    end
    beat(32'h602, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    repeat (5) tick();
    chk("t6 none out", q.size(), 0);
    chk("t6 ok", ok_c, 0);
    chk("t6 bad", bad_c, 0);
    chk("t6 ovf", ovf_c, 0);
    chk("t6 fill", fill, 0);
    send_frame(5, 32'h700, 4'hF, 1'b1);
    wait_beats("t6 count", 5, 30);
    chk_frame("t6", 0, 5, 32'h700, 4'hF);
    chk("t6 ok2", ok_c, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rx_frame_fifo.md
# rx_frame_fifo

Store-and-forward receive frame buffer placed directly downstream of the Rx MAC. It accepts the MAC's AXI-Stream output, which has no back-pressure. Each frame is held until its final beat, where the CRC-good flag is checked. Good frames are released to a back-pressured AXI-Stream master; frames with a bad CRC, an abort or a buffer overflow are discarded by rewinding the write pointer.

## Interface

Parameters:
- DEPTH, 512, buffer entries (beats); power of 2, ≥ 16
- ADDR_W, $clog2(DEPTH), derived; not overridable

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- s_axis_tdata  in  32  frame data from Rx MAC
- s_axis_tkeep  in  4  byte enables
- s_axis_tvalid  in  1  beat valid; there is no tready and input is always accepted
- s_axis_tlast  in  1  frame end event; meaningful even when tvalid=0
- s_axis_tuser  in  1  CRC good; sampled only on the end event
- m_axis_tdata  out  32  released frame data
- m_axis_tkeep  out  4  byte enables
- m_axis_tvalid  out  1  output beat valid
- m_axis_tlast  out  1  last beat of frame
- m_axis_tready  in  1  downstream ready
- o_frames_ok  out  16  committed-frame counter, wraps
- o_frames_bad  out  16  CRC-fail or aborted frames, wraps
- o_frames_ovf  out  16  frames dropped on overflow, wraps
- o_fill  out  ADDR_W+1  entries written and not yet read; includes the uncommitted partial frame

## Operation

- Storage: DEPTH × 37-bit RAM with entry {last, keep[3:0], data[31:0]} and a registered read port.
- Pointers are ADDR_W+1 bits wide; RAM address is ptr[ADDR_W-1:0].
  - wr_ptr: speculative write pointer.
  - cm_ptr: commit pointer.
  - rd_ptr: read pointer.
- Full: wr_ptr − rd_ptr == DEPTH.
- Empty for the reader: rd_ptr == cm_ptr.
- Write FSM has two states, ACCEPT and DISCARD, and resets to ACCEPT.
  - ACCEPT, s_tvalid=1, not full: write {s_tlast, s_tkeep, s_tdata} at wr_ptr, then wr_ptr+1. Beats with tkeep=0 are stored as-is.
  - ACCEPT, s_tvalid=1, full: no write; go to DISCARD.
  - End event = s_tlast=1. It is evaluated after the write decision for the same cycle.
    - Commit: tvalid=1, tuser=1, and the beat was written (not full). Set cm_ptr to wr_ptr+1 and increment o_frames_ok.
    - Otherwise, in ACCEPT (tvalid=0, tuser=0, or full on the last beat): set wr_ptr to cm_ptr and increment o_frames_bad. The full-on-last-beat case instead counts o_frames_ovf and stays in ACCEPT.
  - DISCARD: ignore all beats. On the end event, set wr_ptr to cm_ptr, increment o_frames_ovf, and go to ACCEPT.
- A frame larger than DEPTH entries can never commit and is counted as overflow.
- Read side: two-stage pipeline (RAM read, then output register) with a 2-entry skid. This gives one beat per cycle while m_tready=1.
  - rd_ptr advances only when a read is issued into the pipeline.
  - The pipeline never issues more reads than it has free slots.
- A beat transfers when m_tvalid && m_tready. While m_tvalid=1 and m_tready=0, tdata, tkeep and tlast stay stable.
- Reads never pass cm_ptr, so uncommitted data is never visible.

## Timing

- Reset (one cycle): all pointers = 0, FSM = ACCEPT, skid empty.
  - m_axis_tvalid = 0; m_axis_tdata, tkeep and tlast = 0.
  - All counters = 0; o_fill = 0.
  - Any partial frame is lost. An input end event arriving after reset, with no beats accepted since reset, is counted as bad.
- Commit on the edge ending cycle N: the frame's first beat shows m_tvalid=1 in cycle N+2 when the output path is empty.
- Throughput: 1 beat/cycle in and 1 beat/cycle out, simultaneously.
- Simultaneous commit and read in the same cycle are both honoured.
- A rewind in the same cycle as a read affects only wr_ptr.
- Counters update on the clock edge that ends the end-event cycle. o_fill reflects registered pointers.
- Full is computed from registered pointers. A read in the same cycle does not free space until the next cycle.

## Test plan

- Reset check: after reset, all outputs = 0 and m_tvalid = 0.
- Good frame: 16 beats of data 0x0000_0000..0x0000_000F; last beat tkeep=4'b0011, tuser=1; m_tready=1.
  - Output: identical 16 beats, tlast on beat 16 only, keep 4'b0011 on beat 16.
  - First output beat appears 2 cycles after the last input beat.
  - o_frames_ok = 1.
- Bad CRC, then good frame: 8 beats with tuser=0, then a 4-beat good frame.
  - Only the 4-beat frame is emitted.
  - o_frames_bad = 1, o_frames_ok = 1; o_fill returns to 0.
- Abort: 5 beats, then a cycle with tvalid=0 and tlast=1.
  - Nothing is emitted; o_frames_bad = 1.
  - wr_ptr is restored, so the next good frame lands at its previous address.
- Overflow, DEPTH=16, m_tready=0: a 10-beat good frame commits, then a 10-beat frame arrives.
  - Second frame is dropped; o_frames_ovf = 1.
  - After m_tready=1, exactly 10 beats are emitted.
  - A following 6-beat good frame commits with o_fill peaking at 6.
- Back-pressure: two back-to-back good frames of 7 beats, m_tready randomly toggled.
  - 14 beats are emitted in order with no duplication or loss; data is stable while stalled.
  - Pointers wrap past DEPTH with no corruption.
- Reset mid-frame: assert i_reset during beat 3 of a frame.
  - Nothing is emitted; counters read 0.
  - A subsequent good frame passes normally.
